if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 131 +++++++++++++
 tb/tb_if_id_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a two-entry skid buffer.
// Decouples fetch from decode so in_ready never depends on out_ready.
//
// Ports:
//   clk, reset           clock, async active-high reset
//   in_valid/in_ready    fetch-side handshake
//   in_instr, in_pc4     fetched word and its PC+4
//   flush                drop every held entry (taken branch/jump)
//   out_valid/out_ready  decode-side handshake
//   out_instr, out_pc4   head entry (NOP_INSTR / 0 when empty)
//   opcode..jaddr        field slices of out_instr
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jaddr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] head_instr;
    logic [31:0] head_pc4;
    logic        head_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        skid_valid;

    logic accept;
    logic consume;

    assign accept  = in_valid & in_ready;
    assign consume = head_valid & out_ready;

    // in_ready is a registered output so the fetch side never sees
    // a combinational path back from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            head_instr <= '0;
            head_pc4   <= '0;
            head_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        head_instr <= in_instr;
                        head_pc4   <= in_pc4;
                        head_valid <= 1'b1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_instr <= in_instr;
                        head_pc4   <= in_pc4;
                    end else if (accept) begin
                        // Decode stalled: park the new word behind HEAD.
                        skid_instr <= in_instr;
                        skid_pc4   <= in_pc4;
                        skid_valid <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= FULL;
                    end else if (consume) begin
                        head_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        head_instr <= skid_instr;
                        head_pc4   <= skid_pc4;
                        skid_valid <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready   <= 1'b1;
                    head_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = head_valid;
    assign out_instr = head_valid ? head_instr : NOP_INSTR;
    assign out_pc4   = head_valid ? head_pc4 : 32'h0;

    assign opcode = out_instr[31:26];
    assign rs     = out_instr[25:21];
    assign rt     = out_instr[20:16];
    assign rd     = out_instr[15:11];
    assign shamt  = out_instr[10:6];
    assign funct  = out_instr[5:0];
    assign imm    = out_instr[15:0];
    assign jaddr  = out_instr[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: queue reference model checked every
// negedge, plus directed literal expectations.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jaddr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t q[$];

    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;

    always #5 clk = ~clk;

    if_id_stage #(.NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .jaddr     (jaddr)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // One clock: the model is a plain FIFO of at most two words.
    task automatic step();
        bit acc;
        bit con;
        acc = in_valid && (q.size() < 2);
        con = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back('{instr: in_instr, pc4: in_pc4});
        end
        #1;
    endtask

    always @(negedge clk) begin
        e_valid = (q.size() > 0);
        e_ready = (q.size() < 2);
        e_instr = e_valid ? q[0].instr : NOP;
        e_pc4   = e_valid ? q[0].pc4 : 32'h0;
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        chk("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
        chk("out_instr", out_instr, e_instr);
        chk("out_pc4", out_pc4, e_pc4);
        chk("opcode", {26'b0, opcode}, {26'b0, e_instr[31:26]});
        chk("rs", {27'b0, rs}, {27'b0, e_instr[25:21]});
        chk("rt", {27'b0, rt}, {27'b0, e_instr[20:16]});
        chk("rd", {27'b0, rd}, {27'b0, e_instr[15:11]});
        chk("shamt", {27'b0, shamt}, {27'b0, e_instr[10:6]});
        chk("funct", {26'b0, funct}, {26'b0, e_instr[5:0]});
        chk("imm", {16'b0, imm}, {16'b0, e_instr[15:0]});
        chk("jaddr", {6'b0, jaddr}, {6'b0, e_instr[25:0]});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc4    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_out_pc4", out_pc4, 32'd0);
        chk("rst_jaddr", {6'b0, jaddr}, 32'd0);
        reset = 1'b0;

        // Single transfer, one-cycle latency, field decode.
        in_valid  = 1'b1;
        in_instr  = 32'h2008FFFF;
        in_pc4    = 32'h4;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_opcode", {26'b0, opcode}, 32'h08);
        chk("t1_rt", {27'b0, rt}, 32'd8);
        chk("t1_imm", {16'b0, imm}, 32'hFFFF);
        chk("t1_pc4", out_pc4, 32'h4);
        step();
        chk("t1_drain", {31'b0, out_valid}, 32'd0);

        // Streaming at one per cycle.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h1000_0000 + i;
            in_pc4   = 32'h100 + 4 * i;
            step();
            chk("stream_instr", out_instr, 32'h1000_0000 + i);
            chk("stream_ready", {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();

        // Backpressure: A, B fill the buffer, C is held off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hAAAA_0001; in_pc4 = 32'h10; step();
        in_instr  = 32'hBBBB_0002; in_pc4 = 32'h14; step();
        in_instr  = 32'hCCCC_0003; in_pc4 = 32'h18; step();
        chk("bp_head", out_instr, 32'hAAAA_0001);
        chk("bp_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b", out_instr, 32'hBBBB_0002);
        step();
        in_valid = 1'b0;
        chk("bp_c", out_instr, 32'hCCCC_0003);
        chk("bp_c_pc4", out_pc4, 32'h18);
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with a word on offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hD000_0001; step();
        in_instr  = 32'hE000_0002; step();
        flush     = 1'b1;
        in_instr  = 32'hF000_0003;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_instr", out_instr, NOP);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_gone", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h1234_0001; step();
        in_instr  = 32'h1234_0002; step();
        in_valid  = 1'b0;
        chk("ar_full", {31'b0, in_ready}, 32'd0);
        #1;
        reset = 1'b1;
        q.delete();
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_ready", {31'b0, in_ready}, 32'd1);
        chk("ar_instr", out_instr, NOP);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ar_stale", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_instr = 32'h5555_AAAA;
        in_pc4   = 32'h40;
        step();
        in_valid = 1'b0;
        chk("ar_new", out_instr, 32'h5555_AAAA);
        step();

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = $urandom;
            in_pc4    = $urandom;
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
